// File: rtl/apb_gpio_ctrl.sv
// APB3 GPIO controller: per-pin output/direction, two-flop synchronised inputs.
// Define APB_GPIO_IRQ_EN to build per-pin edge interrupts with W1C status and irq.
module apb_gpio_ctrl #(
    parameter int unsigned DW          = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic [7:0]    PADDR,
    input  logic          PWRITE,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    input  logic [DW-1:0] gpio_i,
    output logic [DW-1:0] gpio_o,
    output logic [DW-1:0] gpio_oe,
    output logic          irq
);
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;
    localparam logic [2:0] WsLoad = 3'(WAIT_STATES);

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic          r_pready;
    logic          r_pslverr;
    logic [DW-1:0] r_prdata;
    logic [DW-1:0] r_out;
    logic [DW-1:0] r_dir;
    logic [DW-1:0] r_sync1;
    logic [DW-1:0] r_sync2;
    logic [2:0]    w_idx;
    logic          w_commit;
    logic          w_wr;
    logic [DW-1:0] w_rdata;
    logic          w_err;
    logic [4:0]    w_unused_addr;

    assign w_idx         = PADDR[4:2];
    assign w_unused_addr = {PADDR[7:5], PADDR[1:0]};
    // Writes land on the edge that ends the PREADY=1 cycle.
    assign w_commit      = (r_state == StAccess) && PSEL && PENABLE && (r_cnt == 3'd0);
    assign w_wr          = w_commit && PWRITE;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
            if (w_wr && w_idx == 3'd0) r_out <= PWDATA;
            if (w_wr && w_idx == 3'd1) r_dir <= PWDATA;
        end
    end

`ifdef APB_GPIO_IRQ_EN
    logic [DW-1:0] r_prev;
    logic [DW-1:0] r_rise_en;
    logic [DW-1:0] r_fall_en;
    logic [DW-1:0] r_status;
    logic          r_irq;
    logic [DW-1:0] w_set;
    logic [DW-1:0] w_clr;

    assign w_set = (r_sync2 & ~r_prev & r_rise_en) | (~r_sync2 & r_prev & r_fall_en);
    assign w_clr = (w_wr && w_idx == 3'd5) ? PWDATA : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prev    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_prev <= r_sync2;
            if (w_wr && w_idx == 3'd3) r_rise_en <= PWDATA;
            if (w_wr && w_idx == 3'd4) r_fall_en <= PWDATA;
            // A new event beats a simultaneous clear.
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= |r_status;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        case (w_idx)
            3'd0: w_rdata = r_out;
            3'd1: w_rdata = r_dir;
            3'd2: w_rdata = r_sync2;
`ifdef APB_GPIO_IRQ_EN
            3'd3: w_rdata = r_rise_en;
            3'd4: w_rdata = r_fall_en;
            3'd5: w_rdata = r_status;
`else
            3'd3, 3'd4, 3'd5: w_rdata = '0;
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= StIdle;
            r_cnt     <= 3'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    if (PSEL) begin
                        r_state <= StAccess;
                        r_cnt   <= WsLoad;
                        if (WsLoad == 3'd0) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= w_rdata;
                        end
                    end
                end
                StAccess: begin
                    if (!PSEL) begin
                        r_state   <= StIdle;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= w_rdata;
                        end
                    end else begin
                        r_state   <= StDone;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign gpio_o  = r_out;
    assign gpio_oe = r_dir;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Scoreboard bench for apb_gpio_ctrl (DW=8, WAIT_STATES=2); adapts expectations to APB_GPIO_IRQ_EN.
module tb_apb_gpio_ctrl;
    localparam int Ws = 2;
`ifdef APB_GPIO_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       psel;
    logic       penable;
    logic [7:0] paddr;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;
    logic [7:0] gpio_oe;
    logic       irq;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       err;
        bit         is_rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    apb_gpio_ctrl #(.DW(8), .WAIT_STATES(Ws)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PSEL    (psel),
        .PENABLE (penable),
        .PADDR   (paddr),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        int   cyc;
        exp_t e;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pready && cyc < 20);
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: no expected entry for completed transfer");
            $fatal(1);
        end
        e = sb.pop_front();
        check_eq({e.tag, "_latency"}, cyc, Ws + 1);
        check_eq({e.tag, "_pslverr"}, pslverr, e.err);
        if (e.is_rd) check_eq(e.tag, prdata, e.data);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp,
                          input logic err);
        sb.push_back('{tag: tag, data: exp, err: err, is_rd: 1'b1});
        apb_xfer(1'b0, addr, 8'h00);
    endtask

    task automatic apb_wr(input string tag, input logic [7:0] addr, input logic [7:0] data,
                          input logic err);
        sb.push_back('{tag: tag, data: 8'h00, err: err, is_rd: 1'b0});
        apb_xfer(1'b1, addr, data);
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        gpio_i = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_gpio_o", gpio_o, 8'h00);
        check_eq("rst_gpio_oe", gpio_oe, 8'h00);
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_pready", pready, 1'b0);
        check_eq("rst_prdata", prdata, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset asserted in the middle of an OUT=0xFF write
        apb_wr("wr_out_3c", 8'h00, 8'h3C, 1'b0);
        check_eq("out_3c", gpio_o, 8'h3C);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_gpio_o", gpio_o, 8'h00);
        check_eq("midrst_gpio_oe", gpio_oe, 8'h00);
        check_eq("midrst_irq", irq, 1'b0);
        check_eq("midrst_pready", pready, 1'b0);
        psel = 1'b0; penable = 1'b0;
        gpio_i = 8'h5A;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        apb_rd("rd_in_5a", 8'h08, 8'h5A, 1'b0);
        apb_rd("rd_out_after_rst", 8'h00, 8'h00, 1'b0);

        // Write/read with wait states
        apb_wr("wr_dir", 8'h04, 8'h0F, 1'b0);
        apb_wr("wr_out", 8'h00, 8'hA5, 1'b0);
        check_eq("gpio_oe_0f", gpio_oe, 8'h0F);
        check_eq("gpio_o_a5", gpio_o, 8'hA5);
        apb_rd("rd_out_a5", 8'h00, 8'hA5, 1'b0);
        apb_rd("rd_dir_alias", 8'hE7, 8'h0F, 1'b0);

        // Edge interrupts: pin 0 rising, pin 7 falling
        gpio_i = 8'h80;
        repeat (4) @(posedge clk);
        apb_rd("rd_status_idle", 8'h14, 8'h00, 1'b0);
        apb_wr("wr_rise_en", 8'h0C, 8'h01, 1'b0);
        apb_wr("wr_fall_en", 8'h10, 8'h80, 1'b0);
        apb_rd("rd_rise_en", 8'h0C, IrqEn ? 8'h01 : 8'h00, 1'b0);
        gpio_i = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("irq_k2", irq, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("irq_k3", irq, IrqEn);
        gpio_i = 8'h09;
        repeat (5) @(posedge clk);
        apb_rd("rd_status_81", 8'h14, IrqEn ? 8'h81 : 8'h00, 1'b0);

        // W1C
        apb_wr("w1c_01", 8'h14, 8'h01, 1'b0);
        apb_rd("rd_status_80", 8'h14, IrqEn ? 8'h80 : 8'h00, 1'b0);
        check_eq("irq_still_set", irq, IrqEn);
        apb_wr("w1c_80", 8'h14, 8'h80, 1'b0);
        @(negedge clk);
        check_eq("irq_lag", irq, IrqEn);
        @(negedge clk);
        check_eq("irq_cleared", irq, 1'b0);
        apb_rd("rd_status_0", 8'h14, 8'h00, 1'b0);

        // Set/clear collision on bit 0
        gpio_i = 8'h08;
        repeat (5) @(posedge clk);
        fork
            apb_wr("w1c_collide", 8'h14, 8'h01, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 gpio_i = 8'h09;
            end
        join
        apb_rd("rd_status_collide", 8'h14, IrqEn ? 8'h01 : 8'h00, 1'b0);
        check_eq("irq_collide", irq, IrqEn);

        // Unmapped accesses
        apb_rd("rd_unmapped_18", 8'h18, 8'h00, 1'b1);
        apb_wr("wr_unmapped_1c", 8'h1C, 8'h55, 1'b1);
        check_eq("gpio_o_keep", gpio_o, 8'hA5);

        // PSEL dropped during a wait state
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        check_eq("drop_pready", pready, 1'b0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("drop_pready_after", pready, 1'b0);
        check_eq("drop_gpio_o", gpio_o, 8'hA5);
        apb_rd("rd_out_after_drop", 8'h00, 8'hA5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
